// File: rtl/chroma_subsample_stream_pkg.sv
// Shared encodings and rounding constants for the streaming chroma subsampler.
package chroma_ds_pkg;

  typedef enum logic [1:0] {
    MODE_444 = 2'd0,
    MODE_422 = 2'd1,
    MODE_420 = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } state_e;

  localparam int unsigned RND_H = 1;
  localparam int unsigned RND_Q = 2;

  // The reserved encoding behaves as bypass.
  function automatic mode_e sanitize_mode(input logic [1:0] m);
    mode_e r;
    case (m)
      2'd1:    r = MODE_422;
      2'd2:    r = MODE_420;
      default: r = MODE_444;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/chroma_subsample_stream_avg_row.sv
// Combinational row averager: horizontal pairs of row_a, or 2x2 quads of row_a/row_b.
module chroma_avg_row
  import chroma_ds_pkg::*;
#(
  parameter int unsigned W = 8,
  parameter int unsigned N = 8
) (
  input  logic [N*W-1:0] i_row_a,
  input  logic [N*W-1:0] i_row_b,
  input  logic           i_sel_420,
  output logic [N*W-1:0] o_avg_row
);

  localparam int unsigned NW = N * W;

  genvar j;
  generate
    for (j = 0; j < N / 2; j++) begin : g_pair
      logic [W-1:0] w_a0, w_a1, w_b0, w_b1;
      logic [W:0]   w_sum_h;
      logic [W+1:0] w_sum_q;

      assign w_a0 = i_row_a[NW-1-(2*j)*W -: W];
      assign w_a1 = i_row_a[NW-1-(2*j+1)*W -: W];
      assign w_b0 = i_row_b[NW-1-(2*j)*W -: W];
      assign w_b1 = i_row_b[NW-1-(2*j+1)*W -: W];

      // Round half up; the widened sums cannot overflow.
      assign w_sum_h = (W+1)'(w_a0) + (W+1)'(w_a1) + (W+1)'(RND_H);
      assign w_sum_q = (W+2)'(w_a0) + (W+2)'(w_a1) + (W+2)'(w_b0) + (W+2)'(w_b1)
                     + (W+2)'(RND_Q);

      assign o_avg_row[NW-1-j*W -: W] = i_sel_420 ? W'(w_sum_q >> 2) : W'(w_sum_h >> 1);
    end
  endgenerate

  assign o_avg_row[NW/2-1:0] = '0;

endmodule

// File: rtl/chroma_subsample_stream.sv
// Row-streaming Cb/Cr subsampler (4:4:4 / 4:2:2 / 4:2:0) with a single registered output stage.
module chroma_subsample_stream
  import chroma_ds_pkg::*;
#(
  parameter int unsigned W = 8,
  parameter int unsigned N = 8
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic [1:0]     i_mode,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic [N*W-1:0] i_cb_row,
  input  logic [N*W-1:0] i_cr_row,
  input  logic           i_in_last,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [N*W-1:0] o_cb_d_row,
  output logic [N*W-1:0] o_cr_d_row,
  output logic           o_out_last,
  output logic           o_blk_err
);

  localparam int unsigned NW = N * W;
  localparam int unsigned RW = (N > 2) ? $clog2(N) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [RW-1:0]   r_row_cnt;
  mode_e           r_mode;
  logic [NW-1:0]   r_cb_buf, r_cr_buf;
  logic [NW-1:0]   r_cb_d, r_cr_d;
  logic            r_out_valid, r_out_last, r_blk_err;

  logic            w_in_fire, w_out_fire, w_is_last_row, w_buffer_row;
  mode_e           w_mode;
  logic [NW-1:0]   w_cb_avg, w_cr_avg;

  assign o_in_ready    = !r_out_valid || i_out_ready;
  assign w_in_fire     = i_in_valid && o_in_ready;
  assign w_out_fire    = r_out_valid && i_out_ready;
  assign w_is_last_row = (r_row_cnt == LAST_ROW);

  // Row 0 takes the live mode; the rest of the block uses the latched one.
  assign w_mode       = (r_state == IDLE) ? sanitize_mode(i_mode) : r_mode;
  assign w_buffer_row = (w_mode == MODE_420) && (r_state != ODD);

  chroma_avg_row #(.W(W), .N(N)) u_avg_cb (
    .i_row_a   (i_cb_row),
    .i_row_b   (r_cb_buf),
    .i_sel_420 (w_mode == MODE_420),
    .o_avg_row (w_cb_avg)
  );

  chroma_avg_row #(.W(W), .N(N)) u_avg_cr (
    .i_row_a   (i_cr_row),
    .i_row_b   (r_cr_buf),
    .i_sel_420 (w_mode == MODE_420),
    .o_avg_row (w_cr_avg)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Row-parity FSM; advances on input transfers only.
  always_comb begin
    w_state_nxt = r_state;
    if (w_in_fire) begin
      case (r_state)
        IDLE, EVEN: w_state_nxt = ODD;
        ODD:        w_state_nxt = w_is_last_row ? IDLE : EVEN;
        default:    w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_row_cnt   <= '0;
      r_mode      <= MODE_444;
      r_cb_buf    <= '0;
      r_cr_buf    <= '0;
      r_cb_d      <= '0;
      r_cr_d      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_blk_err   <= 1'b0;
    end else if (w_in_fire) begin
      r_row_cnt <= w_is_last_row ? '0 : r_row_cnt + RW'(1);
      if (r_state == IDLE) r_mode <= w_mode;
      // Framing errors are flagged but the counter keeps its own count.
      if (i_in_last != w_is_last_row) r_blk_err <= 1'b1;
      if (w_buffer_row) begin
        r_cb_buf    <= i_cb_row;
        r_cr_buf    <= i_cr_row;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end else begin
        r_cb_d      <= (w_mode == MODE_444) ? i_cb_row : w_cb_avg;
        r_cr_d      <= (w_mode == MODE_444) ? i_cr_row : w_cr_avg;
        r_out_valid <= 1'b1;
        r_out_last  <= w_is_last_row;
      end
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_cb_d_row  = r_cb_d;
  assign o_cr_d_row  = r_cr_d;
  assign o_blk_err   = r_blk_err;

endmodule

// File: tb/tb_chroma_subsample_stream.sv
// Self-checking bench for chroma_subsample_stream: directed steps plus random rows against a row-level model.
module tb_chroma_subsample_stream;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 8;
  localparam int unsigned NW = N * W;

  localparam logic [NW-1:0] T_R0 = {8'd111, 8'd111, 8'd111, 8'd110, 8'd109, 8'd109, 8'd108, 8'd108};
  localparam logic [NW-1:0] T_R1 = {8'd110, 8'd110, 8'd110, 8'd109, 8'd108, 8'd108, 8'd107, 8'd107};
  localparam logic [NW-1:0] K_422 = {8'd111, 8'd111, 8'd109, 8'd108, 32'd0};
  localparam logic [NW-1:0] K_420 = {8'd111, 8'd110, 8'd109, 8'd108, 32'd0};

  logic          clk = 1'b0;
  logic          i_reset, i_in_valid, i_in_last, i_out_ready;
  logic [1:0]    i_mode;
  logic [NW-1:0] i_cb_row, i_cr_row;
  logic          o_in_ready, o_out_valid, o_out_last, o_blk_err;
  logic [NW-1:0] o_cb_d_row, o_cr_d_row;

  always #5 clk = ~clk;

  chroma_subsample_stream #(.W(W), .N(N)) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_mode      (i_mode),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_cb_row    (i_cb_row),
    .i_cr_row    (i_cr_row),
    .i_in_last   (i_in_last),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_cb_d_row  (o_cb_d_row),
    .o_cr_d_row  (o_cr_d_row),
    .o_out_last  (o_out_last),
    .o_blk_err   (o_blk_err)
  );

  typedef struct {
    logic [NW-1:0] cb;
    logic [NW-1:0] cr;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  int            pass_cnt = 0;
  int            total_cnt = 0;
  int            m_row = 0;
  int            m_mode = 0;
  logic [NW-1:0] m_prev_cb = '0;
  logic [NW-1:0] m_prev_cr = '0;
  logic          exp_err = 1'b0;
  bit            rand_rdy = 1'b0;

  task automatic chk(input logic [NW-1:0] obs, input logic [NW-1:0] expv, input string tag);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  function automatic int smp(input logic [NW-1:0] r, input int j);
    logic [W-1:0] s;
    s = r[NW-1-j*W -: W];
    return int'(s);
  endfunction

  // Reference row: a = earlier (buffered) row, b = current row.
  function automatic logic [NW-1:0] ref_row(input int m, input logic [NW-1:0] a, input logic [NW-1:0] b);
    logic [NW-1:0] r;
    int v;
    if (m == 0) return b;
    r = '0;
    for (int j = 0; j < N / 2; j++) begin
      if (m == 1) v = (smp(b, 2*j) + smp(b, 2*j+1) + 1) / 2;
      else        v = (smp(a, 2*j) + smp(a, 2*j+1) + smp(b, 2*j) + smp(b, 2*j+1) + 2) / 4;
      r[NW-1-j*W -: W] = W'(v);
    end
    return r;
  endfunction

  function automatic logic [NW-1:0] rnd_row();
    logic [NW-1:0] r;
    for (int j = 0; j < N; j++) r[NW-1-j*W -: W] = W'($urandom);
    return r;
  endfunction

  task automatic model_accept(input logic [NW-1:0] cb, input logic [NW-1:0] cr, input logic last);
    exp_t e;
    if (m_row == 0) m_mode = (i_mode == 2'd3) ? 0 : int'(i_mode);
    if (last != (m_row == N - 1)) exp_err = 1'b1;
    if (m_mode == 2 && (m_row % 2) == 0) begin
      m_prev_cb = cb;
      m_prev_cr = cr;
    end else begin
      e.cb   = ref_row(m_mode, m_prev_cb, cb);
      e.cr   = ref_row(m_mode, m_prev_cr, cr);
      e.last = (m_row == N - 1);
      exp_q.push_back(e);
    end
    m_row = (m_row + 1) % N;
  endtask

  task automatic monitor();
    exp_t e;
    chk(NW'(o_blk_err), NW'(exp_err), "blk_err");
    if (o_out_valid && i_out_ready) begin
      if (exp_q.size() == 0) chk(NW'(o_out_valid), '0, "spurious_out");
      else begin
        e = exp_q.pop_front();
        chk(o_cb_d_row, e.cb, "cb_row");
        chk(o_cr_d_row, e.cr, "cr_row");
        chk(NW'(o_out_last), NW'(e.last), "out_last");
      end
    end
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
    if (rand_rdy) i_out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    post_edge();
  endtask

  task automatic send_row(input logic [NW-1:0] cb, input logic [NW-1:0] cr, input logic last);
    bit ok, rdy;
    ok = 1'b0;
    i_in_valid = 1'b1;
    i_cb_row   = cb;
    i_cr_row   = cr;
    i_in_last  = last;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      monitor();
      rdy = o_in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        model_accept(cb, cr, last);
      end
      if (rand_rdy) i_out_ready = 1'($urandom_range(0, 1));
    end
    i_in_valid = 1'b0;
    chk(NW'(ok), NW'(1), "in_accept");
  endtask

  task automatic send_block(input int m0, input int m_mid, input int mid_at, input int bad_row, input bit same);
    logic [NW-1:0] cb, cr;
    cb = rnd_row();
    cr = rnd_row();
    for (int r = 0; r < N; r++) begin
      if (r == 0) i_mode = 2'(m0);
      if (r == mid_at) i_mode = 2'(m_mid);
      if (!same) begin
        cb = rnd_row();
        cr = rnd_row();
      end
      send_row(cb, cr, (r == N - 1) || (r == bad_row));
    end
  endtask

  task automatic drain();
    rand_rdy    = 1'b0;
    i_out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    chk(NW'(exp_q.size()), '0, "drain_empty");
    for (int k = 0; k < 3; k++) tick();
  endtask

  task automatic do_reset();
    i_reset    = 1'b1;
    i_in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    i_reset   = 1'b0;
    m_row     = 0;
    m_mode    = 0;
    m_prev_cb = '0;
    m_prev_cr = '0;
    exp_err   = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NW-1:0] cb, cr;
    i_reset = 1'b1; i_in_valid = 1'b0; i_in_last = 1'b0; i_out_ready = 1'b1;
    i_mode = 2'd0; i_cb_row = '0; i_cr_row = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    chk(NW'(o_out_valid), '0, "rst_out_valid");
    chk(NW'(o_out_last), '0, "rst_out_last");
    chk(o_cb_d_row, '0, "rst_cb_d");
    chk(o_cr_d_row, '0, "rst_cr_d");
    chk(NW'(o_blk_err), '0, "rst_blk_err");
    chk(NW'(o_in_ready), NW'(1), "rst_in_ready");
    post_edge();

    // 4:2:2 known row
    i_mode = 2'd1;
    send_row(T_R0, rnd_row(), 1'b0);
    @(negedge clk);
    chk(NW'(o_out_valid), NW'(1), "t1_valid");
    chk(o_cb_d_row, K_422, "t1_422_const");
    monitor();
    post_edge();
    for (int r = 1; r < N; r++) send_row(rnd_row(), rnd_row(), r == N - 1);
    drain();

    // 4:2:0 known pair, then rest of block
    i_mode = 2'd2;
    send_row(T_R0, T_R0, 1'b0);
    @(negedge clk);
    chk(NW'(o_out_valid), '0, "t2_no_out_even");
    chk(NW'(o_in_ready), NW'(1), "t2_ready_even");
    monitor();
    post_edge();
    send_row(T_R1, T_R1, 1'b0);
    @(negedge clk);
    chk(o_cb_d_row, K_420, "t2_420_cb_const");
    chk(o_cr_d_row, K_420, "t2_420_cr_const");
    monitor();
    post_edge();
    for (int r = 2; r < N; r++) send_row(rnd_row(), rnd_row(), r == N - 1);
    drain();

    // 4:4:4 identical rows back-to-back
    send_block(0, 0, -1, -1, 1'b1);
    drain();

    // 4:2:2 with 5 cycles of backpressure
    i_mode = 2'd1;
    i_out_ready = 1'b0;
    send_row(rnd_row(), rnd_row(), 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk(NW'(o_in_ready), '0, "bp_in_ready");
      chk(NW'(o_out_valid), NW'(1), "bp_valid");
      chk(o_cb_d_row, exp_q[0].cb, "bp_cb_stable");
      post_edge();
    end
    i_out_ready = 1'b1;
    for (int r = 1; r < N; r++) send_row(rnd_row(), rnd_row(), r == N - 1);
    drain();

    // Mode change mid-block is ignored; next block picks up the new mode
    send_block(2, 1, 3, -1, 1'b0);
    send_block(1, 1, -1, -1, 1'b0);
    drain();

    // Random modes with random downstream stalls
    rand_rdy = 1'b1;
    for (int b = 0; b < 6; b++) send_block(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                                           int'($urandom_range(1, N - 1)), -1, 1'b0);
    drain();

    // Early in_last: sticky error
    send_block(1, 1, -1, 5, 1'b0);
    drain();
    chk(NW'(o_blk_err), NW'(1), "err_sticky");

    // Reset partway into a 4:2:0 block, then a fresh block
    i_mode = 2'd2;
    send_row(rnd_row(), rnd_row(), 1'b0);
    send_row(rnd_row(), rnd_row(), 1'b0);
    tick();
    do_reset();
    @(negedge clk);
    chk(NW'(o_blk_err), '0, "rst_mid_err");
    chk(NW'(o_out_valid), '0, "rst_mid_valid");
    post_edge();
    send_block(2, 2, -1, -1, 1'b0);
    drain();
    cb = rnd_row();
    cr = rnd_row();
    i_mode = 2'd3;
    send_row(cb, cr, 1'b0);
    @(negedge clk);
    chk(o_cb_d_row, cb, "mode3_bypass");
    monitor();
    post_edge();
    for (int r = 1; r < N; r++) send_row(rnd_row(), rnd_row(), r == N - 1);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
